// File: rtl/sync_fifo_if.sv
// sync_fifo_if: push/pop handshake and status bundle for sync_fifo.
interface sync_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                         flush;
    logic                         wr_en;
    logic [WIDTH-1:0]             in;
    logic                         full;
    logic                         rd_en;
    logic [WIDTH-1:0]             data_out;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         underflow;
    modport master (
        output flush, wr_en, in, rd_en,
        input  full, data_out, empty, count, overflow, underflow
    );
    modport slave (
        input  flush, wr_en, in, rd_en,
        output full, data_out, empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous flush and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        reset_n,
    sync_fifo_if.slave bus_io
);
    localparam int PW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             full, empty, push, pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    // A pop at full frees the slot the push lands in on the same edge.
    assign pop   = bus_io.rd_en && !empty;
    assign push  = bus_io.wr_en && (!full || bus_io.rd_en);
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus_io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
            count_d  = count_q + CW'(push) - CW'(pop);
            ovf_d    = ovf_q | (bus_io.wr_en && full && !bus_io.rd_en);
            unf_d    = unf_q | (bus_io.rd_en && empty);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !bus_io.flush) mem_q[wr_ptr_q] <= bus_io.in;
    end
    assign bus_io.full      = full;
    assign bus_io.empty     = empty;
    assign bus_io.count     = count_q;
    assign bus_io.data_out  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus_io.overflow  = ovf_q;
    assign bus_io.underflow = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: vector table plus scoreboard for DEPTH=4, randomized wrap stream for DEPTH=3.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    sync_fifo_if #(.WIDTH(32), .DEPTH(4)) f4 ();
    sync_fifo_if #(.WIDTH(32), .DEPTH(3)) f3 ();
    sync_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus_io(f4));
    sync_fifo #(.WIDTH(32), .DEPTH(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus_io(f3));
    typedef struct {
        logic        fl, wr, rd;
        logic [31:0] din;
        int          cnt;
        logic        emp, ful;
        logic [31:0] dout;
        logic        ovf, unf;
    } vec_t;
    vec_t        tbl [18];
    logic [31:0] q [$];
    int          checks = 0;
    int          errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step(input int i);
        vec_t v;
        logic pu, po;
        v = tbl[i];
        f4.flush = v.fl;
        f4.wr_en = v.wr;
        f4.rd_en = v.rd;
        f4.in    = v.din;
        #1;
        po = !v.fl && v.rd && q.size() > 0;
        pu = !v.fl && v.wr && (q.size() < 4 || v.rd);
        if (po) begin
            chk($sformatf("pop_data[%0d]", i), f4.data_out, q[0]);
            void'(q.pop_front());
        end
        if (pu) q.push_back(v.din);
        if (v.fl) q.delete();
        @(posedge clk);
        #1;
        chk($sformatf("count[%0d]", i), 32'(f4.count), 32'(v.cnt));
        chk($sformatf("empty[%0d]", i), 32'(f4.empty), 32'(v.emp));
        chk($sformatf("full[%0d]", i), 32'(f4.full), 32'(v.ful));
        chk($sformatf("data_out[%0d]", i), f4.data_out, v.dout);
        chk($sformatf("overflow[%0d]", i), 32'(f4.overflow), 32'(v.ovf));
        chk($sformatf("underflow[%0d]", i), 32'(f4.underflow), 32'(v.unf));
        f4.flush = 1'b0;
        f4.wr_en = 1'b0;
        f4.rd_en = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int   sent, got, mc, cyc;
        logic w, r;
        //            fl wr rd din        cnt emp ful dout       ovf unf
        tbl[0]  = '{0, 1, 0, 32'hA0, 1, 0, 0, 32'hA0, 0, 0};
        tbl[1]  = '{0, 1, 0, 32'hA1, 2, 0, 0, 32'hA0, 0, 0};
        tbl[2]  = '{0, 1, 0, 32'hA2, 3, 0, 0, 32'hA0, 0, 0};
        tbl[3]  = '{0, 1, 0, 32'hA3, 4, 0, 1, 32'hA0, 0, 0};
        tbl[4]  = '{0, 1, 0, 32'hFF, 4, 0, 1, 32'hA0, 1, 0};
        tbl[5]  = '{0, 1, 1, 32'hB0, 4, 0, 1, 32'hA1, 1, 0};
        tbl[6]  = '{0, 0, 1, 32'h00, 3, 0, 0, 32'hA2, 1, 0};
        tbl[7]  = '{0, 0, 1, 32'h00, 2, 0, 0, 32'hA3, 1, 0};
        tbl[8]  = '{0, 0, 1, 32'h00, 1, 0, 0, 32'hB0, 1, 0};
        tbl[9]  = '{0, 0, 1, 32'h00, 0, 1, 0, 32'h00, 1, 0};
        tbl[10] = '{0, 0, 1, 32'h00, 0, 1, 0, 32'h00, 1, 1};
        tbl[11] = '{0, 1, 1, 32'hC0, 1, 0, 0, 32'hC0, 1, 1};
        tbl[12] = '{0, 1, 0, 32'hC1, 2, 0, 0, 32'hC0, 1, 1};
        tbl[13] = '{0, 1, 0, 32'hC2, 3, 0, 0, 32'hC0, 1, 1};
        tbl[14] = '{1, 1, 1, 32'hDD, 0, 1, 0, 32'h00, 1, 1};
        tbl[15] = '{0, 1, 0, 32'hE0, 1, 0, 0, 32'hE0, 1, 1};
        tbl[16] = '{0, 0, 0, 32'h00, 1, 0, 0, 32'hE0, 1, 1};
        tbl[17] = '{0, 1, 0, 32'hE1, 2, 0, 0, 32'hE0, 1, 1};
        {f4.flush, f4.wr_en, f4.rd_en, f4.in} = '0;
        {f3.flush, f3.wr_en, f3.rd_en, f3.in} = '0;
        #1;
        chk("rst_count", 32'(f4.count), 0);
        chk("rst_empty", 32'(f4.empty), 1);
        chk("rst_full", 32'(f4.full), 0);
        chk("rst_data_out", f4.data_out, 0);
        chk("rst_overflow", 32'(f4.overflow), 0);
        chk("rst_underflow", 32'(f4.underflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 18; i++) step(i);
        // Async reset lands mid-cycle; outputs must clear before the next edge.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(f4.count), 0);
        chk("arst_empty", 32'(f4.empty), 1);
        chk("arst_full", 32'(f4.full), 0);
        chk("arst_data_out", f4.data_out, 0);
        chk("arst_overflow", 32'(f4.overflow), 0);
        chk("arst_underflow", 32'(f4.underflow), 0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        f4.wr_en = 1'b1;
        f4.in    = 32'h55;
        @(posedge clk);
        #1;
        f4.wr_en = 1'b0;
        chk("post_rst_count", 32'(f4.count), 1);
        chk("post_rst_data_out", f4.data_out, 32'h55);
        @(negedge clk);
        sent = 0;
        got  = 0;
        mc   = 0;
        cyc  = 0;
        while (got < 20 && cyc < 500) begin
            r = (mc > 1 || (sent == 20 && mc > 0)) && ($urandom_range(0, 1) == 1);
            w = sent < 20 && (mc < 3 || r) && ($urandom_range(0, 1) == 1);
            f3.wr_en = w;
            f3.rd_en = r;
            f3.in    = 32'(sent);
            #1;
            if (r) begin
                chk("d3_order", f3.data_out, 32'(got));
                got++;
                mc--;
            end
            if (w) begin
                sent++;
                mc++;
            end
            @(posedge clk);
            #1;
            chk("d3_count", 32'(f3.count), 32'(mc));
            chk("d3_max", 32'(f3.count <= 2'd3 && !f3.overflow && !f3.underflow), 1);
            @(negedge clk);
            cyc++;
        end
        f3.wr_en = 1'b0;
        f3.rd_en = 1'b0;
        chk("d3_done", 32'(got), 20);
        chk("d3_empty", 32'(f3.empty), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous first-word-fall-through FIFO that decouples a producing pipeline stage from a consuming one. Where an enable-driven register chain moves data one stage per cycle with no back-pressure, this block absorbs bursts. The consumer drains entries independently through a pop handshake. It sits between CPU front-end and back-end stages (e.g. fetch-to-decode instruction queue, store buffer), and supports a synchronous flush for pipeline squash on branch mispredict or trap.

## Interface
- WIDTH, 32, bits per entry
- DEPTH, 4, number of entries; any integer ≥ 2 (power of two not required)
- clk  input  1  rising-edge clock; sole clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all entries
- wr_en  input  1  push request
- in  input  WIDTH  push data
- full  output  1  no free entry
- rd_en  input  1  pop request
- data_out  output  WIDTH  head entry (show-ahead)
- empty  output  1  no valid entry
- count  output  $clog2(DEPTH+1)  number of valid entries
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH array; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits (min 1); count register is the source of full/empty.
- Pointer increment wraps DEPTH-1 → 0 explicitly (no reliance on natural binary wrap).
- Accepted push: wr_en && !full, or wr_en && full && rd_en (pop frees a slot the same edge). Writes in at wr_ptr, advances wr_ptr.
- Accepted pop: rd_en && !empty. Advances rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- empty = (count == 0); full = (count == DEPTH); both combinational from count.
- data_out = mem[rd_ptr] when !empty, else all zeros (deterministic for verification).
- Rejected push (wr_en && full && !rd_en): no state change; overflow set.
- Rejected pop (rd_en && empty): no state change; underflow set, even if wr_en is high the same cycle. The pushed word is not bypassed.
- Priority: reset_n low > flush > push/pop.
- flush: pointers and count return to 0 at next edge; push/pop that cycle ignored; overflow/underflow not set by that cycle and not cleared by flush.
- overflow/underflow clear only on reset_n.
- Memory contents are not reset; they are unobservable while empty.

## Timing
- Reset (reset_n low, asynchronous, no clock needed): count=0, empty=1, full=0, data_out=0, overflow=0, underflow=0, pointers=0.
- Reset deassertion is synchronous to clk externally; the first accepted push may occur on the first edge after release.
- Push-to-read latency: 1 cycle. A word pushed at edge N appears on data_out with empty=0 after edge N.
- Pop: the consumer samples data_out in the same cycle rd_en is high; the next entry or empty appears after that edge.
- Full/empty are valid in the same cycle as count; no almost-flags, no combinational path from wr_en/rd_en to any output.
- Sustained throughput 1 push + 1 pop per cycle at any occupancy from 1 to DEPTH.

## Test plan
- Reset/fill/drain: after reset, check empty=1, data_out=0. Push 0xA0..0xA3 (DEPTH=4) on 4 edges → full=1, count=4. Pop 4 → data_out 0xA0,0xA1,0xA2,0xA3 in order, then empty=1, data_out=0.
- Overflow/underflow: on a full FIFO, push 0xFF without pop → count stays 4, overflow=1, contents unchanged. On an empty FIFO, pop → underflow=1, count stays 0. Both flags hold until reset_n is pulsed low.
- Simultaneous push+pop:
  - At count=4, push 0xB0 with pop → pops 0xA0, count stays 4, no overflow.
  - At count=0, push 0xC0 with pop → count=1, data_out=0xC0, underflow=1.
- Wrap-around with DEPTH=3: stream 20 words 0..19, keeping occupancy 1–3 with random push/pop → output order 0..19 exactly, count never exceeds 3.
- Flush: with count=3, assert flush together with wr_en and rd_en → next cycle count=0, empty=1, data_out=0, flags unchanged. A push on the next edge gives data_out = the new word.
- Async reset mid-operation: with count=2, drop reset_n between clock edges → outputs reach reset values before the next edge, and a push after release is read back correctly.
